// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store request bus between the LSU and the data memory responder
interface dmem_responder_if;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wr_data;
    logic        d_ready;
    logic        d_rd_valid;
    logic [31:0] d_rd_data;
    logic        d_err;

    modport master (
        output d_req, d_we, d_size, d_unsigned, d_addr, d_wr_data,
        input  d_ready, d_rd_valid, d_rd_data, d_err
    );

    modport slave (
        input  d_req, d_we, d_size, d_unsigned, d_addr, d_wr_data,
        output d_ready, d_rd_valid, d_rd_data, d_err
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-organised byte-addressable data RAM with one-cycle load responses
// and a post-reset zero-fill sequencer that holds off requests until the array is clean.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic clk,
    input  logic rst,
    dmem_responder_if.slave d
);
    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic {ST_INIT, ST_READY} state_e;

    state_e          state_q;
    logic [AW-1:0]   clr_cnt_q;
    logic            ready_q;
    logic            rd_valid_q;
    logic            err_q;
    logic [31:0]     rd_data_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic [31:0]     off;
    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic            in_range;
    logic            req_err;
    logic            accept;
    logic            store_en;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [31:0]     rd_word;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     ld_data;

    assign off      = d.d_addr - BASE_ADDR;
    assign idx      = off[AW+1:2];
    assign lane     = off[1:0];
    assign in_range = off < SPAN;
    assign accept   = d.d_req & ready_q;
    assign store_en = accept & d.d_we & ~req_err & ~rst;

    always_comb begin
        req_err = ~in_range;
        case (d.d_size)
            2'd1:    if (lane[0])       req_err = 1'b1;
            2'd2:    if (lane != 2'd0)  req_err = 1'b1;
            2'd3:    req_err = 1'b1;
            default: ;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        be    = 4'b0000;
        wdata = d.d_wr_data;
        case (d.d_size)
            2'd0: begin
                be    = 4'b0001 << lane;
                wdata = {4{d.d_wr_data[7:0]}};
            end
            2'd1: begin
                be    = 4'b0011 << lane;
                wdata = {2{d.d_wr_data[15:0]}};
            end
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign rd_word  = mem[idx];
    assign byte_sel = rd_word[{lane, 3'b000} +: 8];
    assign half_sel = rd_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        case (d.d_size)
            2'd0:    ld_data = d.d_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'd1:    ld_data = d.d_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ld_data = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT && CLEAR_ON_RESET) begin
                mem[clr_cnt_q] <= '0;
            end else if (store_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            clr_cnt_q  <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= accept & ~d.d_we;
            err_q      <= accept & req_err;
            if (accept && !d.d_we) rd_data_q <= req_err ? 32'h0 : ld_data;
            case (state_q)
                ST_INIT: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (!CLEAR_ON_RESET || clr_cnt_q == AW'(DEPTH_WORDS - 1)) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    assign d.d_ready    = ready_q;
    assign d.d_rd_valid = rd_valid_q;
    assign d.d_rd_data  = rd_data_q;
    assign d.d_err      = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - bench for dmem_responder: scripted scenarios plus random traffic
// against a word-array reference model.
module tb_dmem_responder;
    localparam logic [31:0] BASE0 = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst0 = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if if1();
    dmem_responder_if if0();

    dmem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .CLEAR_ON_RESET(1'b1))
        dut1 (.clk(clk), .rst(rst1), .d(if1));
    dmem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(BASE0), .CLEAR_ON_RESET(1'b0))
        dut0 (.clk(clk), .rst(rst0), .d(if0));

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] mdl [2][16];
    logic [31:0] last_data [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input bit req, input bit we, input logic [1:0] size,
                         input bit uns, input logic [31:0] addr, input logic [31:0] wd);
        if (sel == 1) begin
            if1.d_req = req; if1.d_we = we; if1.d_size = size;
            if1.d_unsigned = uns; if1.d_addr = addr; if1.d_wr_data = wd;
        end else begin
            if0.d_req = req; if0.d_we = we; if0.d_size = size;
            if0.d_unsigned = uns; if0.d_addr = addr; if0.d_wr_data = wd;
        end
    endtask

    task automatic sample(input int sel, output logic rdy, output logic vld, output logic err,
                          output logic [31:0] data);
        if (sel == 1) begin
            rdy = if1.d_ready; vld = if1.d_rd_valid; err = if1.d_err; data = if1.d_rd_data;
        end else begin
            rdy = if0.d_ready; vld = if0.d_rd_valid; err = if0.d_err; data = if0.d_rd_data;
        end
    endtask

    function automatic logic [31:0] base_of(input int sel);
        return (sel == 1) ? 32'h0 : BASE0;
    endfunction

    function automatic bit is_err(input int sel, input logic [1:0] size, input logic [31:0] addr);
        logic [31:0] off;
        off = addr - base_of(sel);
        return (size == 2'd3) || (off >= 32'd64) || (size == 2'd1 && off % 2 != 0) ||
               (size == 2'd2 && off % 4 != 0);
    endfunction

    function automatic logic [31:0] load_val(input int sel, input logic [1:0] size, input bit uns,
                                             input logic [31:0] addr);
        logic [31:0] off, v, x;
        int sh;
        off = addr - base_of(sel);
        v   = mdl[sel][off[5:2]];
        sh  = 8 * int'(off[1:0]);
        case (size)
            2'd0: begin
                x = (v >> sh) & 32'hFF;
                if (!uns && x >= 32'd128) x = x - 32'd256;
            end
            2'd1: begin
                x = (v >> sh) & 32'hFFFF;
                if (!uns && x >= 32'd32768) x = x - 32'd65536;
            end
            default: x = v;
        endcase
        return x;
    endfunction

    task automatic store_model(input int sel, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wd);
        logic [31:0] off, mask, val;
        int sh;
        off = addr - base_of(sel);
        sh  = 8 * int'(off[1:0]);
        case (size)
            2'd0:    begin mask = 32'hFF << sh;   val = (wd & 32'hFF) << sh;   end
            2'd1:    begin mask = 32'hFFFF << sh; val = (wd & 32'hFFFF) << sh; end
            default: begin mask = 32'hFFFF_FFFF;  val = wd;                    end
        endcase
        mdl[sel][off[5:2]] = (mdl[sel][off[5:2]] & ~mask) | val;
    endtask

    task automatic req(input int sel, input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd, input string tag,
                       output logic [31:0] got);
        logic rdy, vld, err;
        logic [31:0] data, exp;
        bit e;
        e   = is_err(sel, size, addr);
        exp = e ? 32'h0 : load_val(sel, size, uns, addr);
        drive(sel, 1'b1, we, size, uns, addr, wd);
        @(posedge clk); #1;
        sample(sel, rdy, vld, err, data);
        if (we) begin
            if (!e) store_model(sel, size, addr, wd);
            check({tag, "_vld"}, 32'(vld), 32'd0);
            check({tag, "_err"}, 32'(err), 32'(e));
            check({tag, "_hold"}, data, last_data[sel]);
        end else begin
            check({tag, "_vld"}, 32'(vld), 32'd1);
            check({tag, "_err"}, 32'(err), 32'(e));
            check({tag, "_data"}, data, exp);
            last_data[sel] = exp;
        end
        got = data;
        drive(sel, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic idle(input int sel);
        logic rdy, vld, err;
        logic [31:0] data;
        drive(sel, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        sample(sel, rdy, vld, err, data);
        check("idle_vld", 32'(vld), 32'd0);
        check("idle_err", 32'(err), 32'd0);
        check("idle_hold", data, last_data[sel]);
    endtask

    initial begin
        logic rdy, vld, err;
        logic [31:0] data, g, addr;
        for (int s = 0; s < 2; s++) begin
            last_data[s] = 32'h0;
            for (int w = 0; w < 16; w++) mdl[s][w] = 32'h0;
        end
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        // Zero-fill: request held throughout INIT must not be serviced until d_ready rises.
        drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        sample(1, rdy, vld, err, data);
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_vld", 32'(vld), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data", data, 32'h0);
        rst1 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            sample(1, rdy, vld, err, data);
            check($sformatf("init_rdy%0d", k), 32'(rdy), 32'(k == 16));
            check($sformatf("init_vld%0d", k), 32'(vld), 32'd0);
        end
        @(posedge clk); #1;
        sample(1, rdy, vld, err, data);
        check("first_vld", 32'(vld), 32'd1);
        check("first_err", 32'(err), 32'd0);
        check("first_data", data, 32'h0);
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);

        req(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "sw10", g);
        req(1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "lb13", g);  check("lb13_k", g, 32'hFFFFFFDE);
        req(1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "lbu13", g); check("lbu13_k", g, 32'h000000DE);
        req(1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, "lh12", g);  check("lh12_k", g, 32'hFFFFDEAD);
        req(1, 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, "lhu10", g); check("lhu10_k", g, 32'h0000BEEF);
        req(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10", g);  check("lw10_k", g, 32'hDEADBEEF);

        req(1, 1'b1, 2'd0, 1'b0, 32'h11, 32'h12345655, "sb11", g);
        req(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10b", g); check("lw10b_k", g, 32'hDEAD55EF);
        req(1, 1'b1, 2'd1, 1'b0, 32'h16, 32'hAAAA8001, "sh16", g);
        req(1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, "lw14", g);  check("lw14_k", g, 32'h80010000);

        req(1, 1'b0, 2'd2, 1'b0, 32'h12, 32'h0, "lw12_mis", g);   check("lw12_k", g, 32'h0);
        req(1, 1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFF, "sh11_mis", g);
        req(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10c", g); check("lw10c_k", g, 32'hDEAD55EF);
        req(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, "lw40_oor", g);
        req(1, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, "sz3", g);
        idle(1);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                addr = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 71));
                req(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    addr, 32'($urandom), $sformatf("rnd%0d", n), g);
            end
        end

        // Request accepted with rst high is dropped; a second reset mid-fill restarts the clear.
        rst1 = 1'b1;
        drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        sample(1, rdy, vld, err, data);
        check("mid_vld", 32'(vld), 32'd0);
        check("mid_err", 32'(err), 32'd0);
        check("mid_rdy", 32'(rdy), 32'd0);
        check("mid_data", data, 32'h0);
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        last_data[1] = 32'h0;
        rst1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            sample(1, rdy, vld, err, data);
            check($sformatf("rinit_rdy%0d", k), 32'(rdy), 32'd0);
        end
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            sample(1, rdy, vld, err, data);
            check($sformatf("rinit2_rdy%0d", k), 32'(rdy), 32'(k == 16));
        end
        for (int w = 0; w < 16; w++) mdl[1][w] = 32'h0;
        req(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "clr10", g);
        req(1, 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, "clr3c", g);

        sample(0, rdy, vld, err, data);
        check("nc_rst_rdy", 32'(rdy), 32'd0);
        rst0 = 1'b0;
        @(posedge clk); #1;
        sample(0, rdy, vld, err, data);
        check("nc_rdy", 32'(rdy), 32'd1);
        req(0, 1'b1, 2'd2, 1'b0, BASE0, 32'h00000080, "nc_sw", g);
        req(0, 1'b0, 2'd0, 1'b0, BASE0, 32'h0, "nc_lb", g);   check("nc_lb_k", g, 32'hFFFFFF80);
        req(0, 1'b0, 2'd0, 1'b1, BASE0, 32'h0, "nc_lbu", g);  check("nc_lbu_k", g, 32'h00000080);
        req(0, 1'b0, 2'd2, 1'b0, BASE0 - 32'd4, 32'h0, "nc_below", g);
        req(0, 1'b0, 2'd2, 1'b0, BASE0 + 32'd64, 32'h0, "nc_above", g);

        rst0 = 1'b1;
        drive(0, 1'b1, 1'b1, 2'd2, 1'b0, BASE0, 32'h11111111);
        @(posedge clk); #1;
        sample(0, rdy, vld, err, data);
        check("nc_rstst_vld", 32'(vld), 32'd0);
        check("nc_rstst_err", 32'(err), 32'd0);
        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        last_data[0] = 32'h0;
        rst0 = 1'b0;
        @(posedge clk); #1;
        sample(0, rdy, vld, err, data);
        check("nc_rdy2", 32'(rdy), 32'd1);
        req(0, 1'b0, 2'd2, 1'b0, BASE0, 32'h0, "nc_keep", g); check("nc_keep_k", g, 32'h00000080);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that services load/store requests issued by the load/store unit on the d_* interface.
- Single-port, word-organised, byte-addressable RAM.
- Fixed one-cycle read latency.
- Byte/half/word stores with lane enables.
- Load-data extraction with sign/zero extension.
- Error response for misaligned, out-of-range or illegal requests.
- Post-reset zero-fill sequencer; requests are not accepted until it completes.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = skip the fill.

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  reset, synchronous active-high
d_req  input  1  request valid this cycle
d_we  input  1  1 = store, 0 = load; qualified by d_req
d_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
d_unsigned  input  1  load zero-extends when 1 (LBU/LHU); ignored for stores and word loads
d_addr  input  32  byte address
d_wr_data  input  32  store data, right-justified (byte in [7:0], half in [15:0])
d_ready  output  1  responder accepting requests
d_rd_valid  output  1  load response valid (one-cycle pulse per accepted load)
d_rd_data  output  32  formatted load data
d_err  output  1  error flag for the request accepted in the previous cycle

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values, in the cycle after rst is sampled high: d_ready=0, d_rd_valid=0, d_rd_data=0, d_err=0, FSM=INIT, clear counter=0.
- FSM states:
  - INIT, CLEAR_ON_RESET=1: each cycle write 0 to word[clr_cnt] and increment clr_cnt. After writing word DEPTH_WORDS-1, go to READY.
  - INIT, CLEAR_ON_RESET=0: go to READY on the first non-reset cycle.
  - READY: d_ready=1. Leave only on rst.
  - d_ready rises exactly DEPTH_WORDS cycles after rst deasserts (1 cycle if CLEAR_ON_RESET=0).
- Acceptance: a request is accepted when d_req & d_ready. A request with d_req=1 while d_ready=0 is dropped: no memory effect, no response. Throughput is one request per cycle, with no stall once READY.
- Decode: off = d_addr - BASE_ADDR (32-bit wrap). The request is in range iff off < DEPTH_WORDS*4. Word index = off[log2(DEPTH_WORDS)+1:2]. Lane = off[1:0].
- Error conditions, any of:
  - d_size == 3
  - half with lane[0] == 1
  - word with lane != 0
  - out of range
- Store, accepted and no error: written at the accepting edge.
  - Byte: enable 4'b0001 << lane, d_wr_data[7:0] replicated across all lanes.
  - Half: enable 4'b0011 << lane, d_wr_data[15:0] replicated.
  - Word: enable 4'b1111.
  - Unenabled bytes are unchanged.
- Store, accepted with error: memory is unchanged. In the next cycle d_err=1 and d_rd_valid=0.
- Load, accepted: in the next cycle d_rd_valid=1 and d_err reflects the error.
  - No error: d_rd_data = selected byte/half from the stored word at lane, sign-extended if d_unsigned=0, else zero-extended. Word loads return the whole word.
  - Error: d_rd_data = 0.
- Idle cycles: d_rd_valid=0 and d_err=0 in any cycle not following an accepted load or error store. d_rd_data holds its last value when d_rd_valid=0.
- Store followed by load: a load accepted in the cycle after a store to the same word returns the updated data.
- Reset mid-operation:
  - A response owed for a request accepted in the cycle rst is high is suppressed (d_rd_valid=0, d_err=0 next cycle).
  - A store accepted in that cycle is not written.
  - Reset during INIT restarts the clear from word 0.
- Memory contents are undefined only when CLEAR_ON_RESET=0 and no prior write has occurred.

Test Plan:
- DEPTH_WORDS=16, CLEAR_ON_RESET=1: pulse rst 1 cycle, hold d_req=1 load word 0x0 throughout -> d_ready low 16 cycles then high; no d_rd_valid during INIT; first accepted LW returns 0 with d_rd_valid one cycle later.
- SW 0xDEADBEEF @0x10, then LB 0x13 / LBU 0x13 / LH 0x12 / LHU 0x10 / LW 0x10 back-to-back -> 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000BEEF, 0xDEADBEEF, each one cycle after its request.
- After the previous scenario: SB 0x11 data 0x12345655, then SH 0x16 data 0xAAAA8001, then LW 0x10 and LW 0x14 -> 0xDEAD55EF and 0x80010000, with the LW issued the cycle right after the store.
- Errors: LW 0x12 -> d_rd_valid=1, d_err=1, data 0. SH 0x11 data 0xFFFF -> d_err=1, d_rd_valid=0, then LW 0x10 is unchanged. LW at BASE_ADDR+64 (DEPTH 16) -> d_err=1. d_size=3 -> d_err=1.
- Reset mid-transaction: accept LW with rst high in the same cycle -> no d_rd_valid next cycle, d_ready=0, INIT restarts. Assert rst again at INIT cycle 5 -> d_ready rises 16 cycles after the final rst deassert.
- CLEAR_ON_RESET=0: after rst, d_ready=1 on the first non-reset cycle. SW 0x00000080 @0x0 then LB 0x0 -> 0xFFFFFF80; LBU 0x0 -> 0x00000080.
